pw_pattern_generator: RTL and testbench

Programmable byte-stream source for the front-end data path. It emits a stored pattern of up to pPATTERN_BYTES bytes as an fe_data/fe_data_valid stream, with configurable inter-byte gaps, inter-repetition gaps and repeat count. It sits in front of the pattern matcher, muxed onto its data input, and serves as the built-in self-test stimulus for trigger and capture logic. Byte order matches the matcher: byte 0 is I_pattern[7:0] and is sent first.

---
 rtl/pw_pattern_generator.sv | 192 +++++++++++++++++++
 tb/tb_pw_pattern_generator.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_pattern_generator.sv
// Programmable byte-stream source: replays a latched pattern with inter-byte and inter-repetition gaps.
// Optional macro PW_PATGEN_FILLER_EN drives the latched filler byte as valid data during REPGAP cycles.
module pw_pattern_generator #(
  parameter int pPATTERN_BYTES = 8
) (
  input  logic                        fe_clk,
  input  logic                        reset_i,
  input  logic                        I_start,
  input  logic                        I_abort,
  input  logic [pPATTERN_BYTES*8-1:0] I_pattern,
  input  logic [7:0]                  I_pattern_bytes,
  input  logic [7:0]                  I_gap,
  input  logic [7:0]                  I_rep_gap,
  input  logic [7:0]                  I_repeat,
  input  logic [7:0]                  I_filler,
  output logic [7:0]                  O_data,
  output logic                        O_data_valid,
  output logic                        O_busy,
  output logic                        O_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEND   = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_REPGAP = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [7:0] MAX_BYTES = 8'(pPATTERN_BYTES);

  logic [2:0]                  state_q, state_n;
  logic [7:0]                  idx_q, idx_n;
  logic [7:0]                  rep_q, rep_n;
  logic [7:0]                  gcnt_q, gcnt_n;
  logic [pPATTERN_BYTES*8-1:0] pat_q, pat_n;
  logic [7:0]                  last_q, last_n;
  logic [7:0]                  gap_q, gap_n;
  logic [7:0]                  rgap_q, rgap_n;
  logic [7:0]                  rpt_q, rpt_n;
  logic [7:0]                  last_idx_in;
  logic [7:0]                  data_n;
  logic                        valid_n;
  logic                        busy_n;
  logic                        done_n;

`ifdef PW_PATGEN_FILLER_EN
  logic [7:0]                  fill_q, fill_n;
`else
  logic                        unused_filler;
  assign unused_filler = ^I_filler;
`endif

  function automatic logic [7:0] pick_byte(input logic [pPATTERN_BYTES*8-1:0] pat,
                                           input logic [7:0] idx);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < pPATTERN_BYTES; k++) begin
      if (idx == 8'(k)) b = pat[k*8 +: 8];
    end
    return b;
  endfunction

  // Length 0 behaves as 1 and oversize lengths clamp, so the stored value is a last-index.
  always_comb begin
    if (I_pattern_bytes == 8'd0)
      last_idx_in = 8'd0;
    else if (I_pattern_bytes > MAX_BYTES)
      last_idx_in = MAX_BYTES - 8'd1;
    else
      last_idx_in = I_pattern_bytes - 8'd1;
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    rep_n   = rep_q;
    gcnt_n  = gcnt_q;
    pat_n   = pat_q;
    last_n  = last_q;
    gap_n   = gap_q;
    rgap_n  = rgap_q;
    rpt_n   = rpt_q;
`ifdef PW_PATGEN_FILLER_EN
    fill_n  = fill_q;
`endif
    if (I_abort) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      rep_n   = '0;
      gcnt_n  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (I_start) begin
            state_n = ST_SEND;
            idx_n   = '0;
            rep_n   = '0;
            gcnt_n  = '0;
            pat_n   = I_pattern;
            last_n  = last_idx_in;
            gap_n   = I_gap;
            rgap_n  = I_rep_gap;
            rpt_n   = I_repeat;
`ifdef PW_PATGEN_FILLER_EN
            fill_n  = I_filler;
`endif
          end
        end
        ST_SEND: begin
          if (idx_q < last_q) begin
            idx_n = idx_q + 8'd1;
            if (gap_q != 8'd0) begin
              state_n = ST_GAP;
              gcnt_n  = gap_q - 8'd1;
            end
          end else if (rep_q < rpt_q) begin
            idx_n = '0;
            rep_n = rep_q + 8'd1;
            if (rgap_q != 8'd0) begin
              state_n = ST_REPGAP;
              gcnt_n  = rgap_q - 8'd1;
            end
          end else begin
            state_n = ST_DONE;
            idx_n   = '0;
            rep_n   = '0;
          end
        end
        ST_GAP, ST_REPGAP: begin
          if (gcnt_q == 8'd0)
            state_n = ST_SEND;
          else
            gcnt_n = gcnt_q - 8'd1;
        end
        ST_DONE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    busy_n  = (state_n == ST_SEND) || (state_n == ST_GAP) || (state_n == ST_REPGAP);
    done_n  = (state_n == ST_DONE);
    valid_n = (state_n == ST_SEND);
    data_n  = (state_n == ST_SEND) ? pick_byte(pat_n, idx_n) : 8'd0;
`ifdef PW_PATGEN_FILLER_EN
    if (state_n == ST_REPGAP) begin
      valid_n = 1'b1;
      data_n  = fill_n;
    end
`endif
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      rep_q        <= '0;
      gcnt_q       <= '0;
      pat_q        <= '0;
      last_q       <= '0;
      gap_q        <= '0;
      rgap_q       <= '0;
      rpt_q        <= '0;
`ifdef PW_PATGEN_FILLER_EN
      fill_q       <= '0;
`endif
      O_data       <= '0;
      O_data_valid <= 1'b0;
      O_busy       <= 1'b0;
      O_done       <= 1'b0;
    end else begin
      state_q      <= state_n;
      idx_q        <= idx_n;
      rep_q        <= rep_n;
      gcnt_q       <= gcnt_n;
      pat_q        <= pat_n;
      last_q       <= last_n;
      gap_q        <= gap_n;
      rgap_q       <= rgap_n;
      rpt_q        <= rpt_n;
`ifdef PW_PATGEN_FILLER_EN
      fill_q       <= fill_n;
`endif
      O_data       <= data_n;
      O_data_valid <= valid_n;
      O_busy       <= busy_n;
      O_done       <= done_n;
    end
  end

endmodule

// File: tb/tb_pw_pattern_generator.sv
// Directed bench for pw_pattern_generator: per-cycle vector table plus hand-written corner sequences.
// Filler expectations follow PW_PATGEN_FILLER_EN when the bench is built with it.
module tb_pw_pattern_generator;

  logic        fe_clk = 1'b0;
  logic        reset_i;
  logic        I_start;
  logic        I_abort;
  logic [63:0] I_pattern;
  logic [7:0]  I_pattern_bytes;
  logic [7:0]  I_gap;
  logic [7:0]  I_rep_gap;
  logic [7:0]  I_repeat;
  logic [7:0]  I_filler;
  logic [7:0]  O_data;
  logic        O_data_valid;
  logic        O_busy;
  logic        O_done;

  int err_count   = 0;
  int check_count = 0;

`ifdef PW_PATGEN_FILLER_EN
  localparam logic       FV = 1'b1;
  localparam logic [7:0] FD = 8'hEE;
`else
  localparam logic       FV = 1'b0;
  localparam logic [7:0] FD = 8'h00;
`endif

  typedef struct {
    logic        start;
    logic        abort;
    logic [63:0] pattern;
    logic [7:0]  nbytes;
    logic [7:0]  gap;
    logic [7:0]  rgap;
    logic [7:0]  rpt;
    logic [7:0]  filler;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t        vecs[64];
  int          nvec = 0;
  logic [63:0] cfg_pattern;
  logic [7:0]  cfg_nbytes, cfg_gap, cfg_rgap, cfg_rpt, cfg_filler;

  pw_pattern_generator #(.pPATTERN_BYTES(8)) dut (
    .fe_clk          (fe_clk),
    .reset_i         (reset_i),
    .I_start         (I_start),
    .I_abort         (I_abort),
    .I_pattern       (I_pattern),
    .I_pattern_bytes (I_pattern_bytes),
    .I_gap           (I_gap),
    .I_rep_gap       (I_rep_gap),
    .I_repeat        (I_repeat),
    .I_filler        (I_filler),
    .O_data          (O_data),
    .O_data_valid    (O_data_valid),
    .O_busy          (O_busy),
    .O_done          (O_done)
  );

  always #5 fe_clk = ~fe_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic add_vec(input logic s, input logic a, input logic v, input logic [7:0] d,
                         input logic b, input logic dn);
    vecs[nvec].start     = s;
    vecs[nvec].abort     = a;
    vecs[nvec].pattern   = cfg_pattern;
    vecs[nvec].nbytes    = cfg_nbytes;
    vecs[nvec].gap       = cfg_gap;
    vecs[nvec].rgap      = cfg_rgap;
    vecs[nvec].rpt       = cfg_rpt;
    vecs[nvec].filler    = cfg_filler;
    vecs[nvec].exp_valid = v;
    vecs[nvec].exp_data  = d;
    vecs[nvec].exp_busy  = b;
    vecs[nvec].exp_done  = dn;
    nvec++;
  endtask

  task automatic set_cfg(input logic [63:0] p, input logic [7:0] n, input logic [7:0] g,
                         input logic [7:0] r, input logic [7:0] pg, input logic [7:0] f);
    cfg_pattern = p;
    cfg_nbytes  = n;
    cfg_rpt     = r;
    cfg_gap     = g;
    cfg_rgap    = pg;
    cfg_filler  = f;
  endtask

  task automatic apply_stimulus(input vec_t v);
    I_start         = v.start;
    I_abort         = v.abort;
    I_pattern       = v.pattern;
    I_pattern_bytes = v.nbytes;
    I_gap           = v.gap;
    I_rep_gap       = v.rgap;
    I_repeat        = v.rpt;
    I_filler        = v.filler;
  endtask

  task automatic drive_cfg();
    I_pattern       = cfg_pattern;
    I_pattern_bytes = cfg_nbytes;
    I_gap           = cfg_gap;
    I_rep_gap       = cfg_rgap;
    I_repeat        = cfg_rpt;
    I_filler        = cfg_filler;
  endtask

  task automatic step();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    check_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [7:0] d,
                           input logic b, input logic dn);
    check_output({tag, ".valid"}, {7'd0, O_data_valid}, {7'd0, v});
    check_output({tag, ".data"},  O_data,               d);
    check_output({tag, ".busy"},  {7'd0, O_busy},       {7'd0, b});
    check_output({tag, ".done"},  {7'd0, O_done},       {7'd0, dn});
  endtask

  initial begin
    int          cnt;
    logic        done_seen;
    logic [63:0] exp_pat;

    reset_i = 1'b1;
    I_start = 1'b0;
    I_abort = 1'b0;
    set_cfg(64'h0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    drive_cfg();
    step();
    step();
    check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    reset_i = 1'b0;
    step();

    // Basic pass: N=3, no gaps, one pass.
    set_cfg(64'hC3B2A1, 8'd3, 8'd0, 8'd0, 8'd0, 8'h00);
    add_vec(1, 0, 1, 8'hA1, 1, 0);
    add_vec(0, 0, 1, 8'hB2, 1, 0);
    add_vec(0, 0, 1, 8'hC3, 1, 0);
    add_vec(0, 0, 0, 8'h00, 0, 1);
    add_vec(0, 0, 0, 8'h00, 0, 0);
    // Gaps and repeats: N=2, G=2, R=1, P=3.
    set_cfg(64'h2211, 8'd2, 8'd2, 8'd1, 8'd3, 8'hEE);
    add_vec(1, 0, 1, 8'h11, 1, 0);
    add_vec(0, 0, 0, 8'h00, 1, 0);
    add_vec(0, 0, 0, 8'h00, 1, 0);
    add_vec(0, 0, 1, 8'h22, 1, 0);
    add_vec(0, 0, FV, FD, 1, 0);
    add_vec(0, 0, FV, FD, 1, 0);
    add_vec(0, 0, FV, FD, 1, 0);
    add_vec(0, 0, 1, 8'h11, 1, 0);
    add_vec(0, 0, 0, 8'h00, 1, 0);
    add_vec(0, 0, 0, 8'h00, 1, 0);
    add_vec(0, 0, 1, 8'h22, 1, 0);
    add_vec(0, 0, 0, 8'h00, 0, 1);
    add_vec(0, 0, 0, 8'h00, 0, 0);
    // Latching and start-ignore: config changes and start pulses mid-run have no effect.
    set_cfg(64'hC3B2A1, 8'd3, 8'd1, 8'd0, 8'd0, 8'h00);
    add_vec(1, 0, 1, 8'hA1, 1, 0);
    set_cfg(64'h0, 8'd1, 8'd0, 8'd0, 8'd0, 8'h00);
    add_vec(1, 0, 0, 8'h00, 1, 0);
    add_vec(0, 0, 1, 8'hB2, 1, 0);
    add_vec(1, 0, 0, 8'h00, 1, 0);
    add_vec(0, 0, 1, 8'hC3, 1, 0);
    add_vec(0, 0, 0, 8'h00, 0, 1);
    add_vec(1, 0, 0, 8'h00, 0, 0);
    add_vec(0, 0, 0, 8'h00, 0, 0);
    // Abort and start together in IDLE stays idle.
    add_vec(1, 1, 0, 8'h00, 0, 0);
    add_vec(0, 0, 0, 8'h00, 0, 0);

    for (int i = 0; i < nvec; i++) begin
      apply_stimulus(vecs[i]);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                vecs[i].exp_busy, vecs[i].exp_done);
    end
    I_start = 1'b0;
    I_abort = 1'b0;

    // Clamp N=0 to one byte.
    set_cfg(64'h2211, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00);
    drive_cfg();
    I_start = 1'b1;
    step();
    I_start = 1'b0;
    check_all("n0.byte", 1'b1, 8'h11, 1'b1, 1'b0);
    step();
    check_all("n0.done", 1'b0, 8'h00, 1'b0, 1'b1);
    step();

    // Clamp N=20 to eight bytes.
    exp_pat = 64'h8877665544332211;
    set_cfg(exp_pat, 8'd20, 8'd0, 8'd0, 8'd0, 8'h00);
    drive_cfg();
    I_start = 1'b1;
    step();
    I_start = 1'b0;
    cnt = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (O_done) begin
        done_seen = 1'b1;
      end else begin
        if (O_data_valid && cnt < 8) check_output($sformatf("n20.byte%0d", cnt), O_data, exp_pat[cnt*8 +: 8]);
        if (O_data_valid) cnt++;
        step();
      end
    end
    check_output("n20.done_seen", {7'd0, done_seen}, 8'd1);
    check_output("n20.count", 8'(cnt), 8'd8);
    step();

    // Abort in the middle of an inter-byte gap.
    set_cfg(64'h44332211, 8'd4, 8'd5, 8'd0, 8'd0, 8'h00);
    drive_cfg();
    I_start = 1'b1;
    step();
    I_start = 1'b0;
    check_all("abort.b0", 1'b1, 8'h11, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step();
    check_all("abort.b1", 1'b1, 8'h22, 1'b1, 1'b0);
    step();
    step();
    I_abort = 1'b1;
    step();
    I_abort = 1'b0;
    check_all("abort.after", 1'b0, 8'h00, 1'b0, 1'b0);
    I_start = 1'b1;
    step();
    I_start = 1'b0;
    check_all("abort.restart", 1'b1, 8'h11, 1'b1, 1'b0);
    I_abort = 1'b1;
    step();
    I_abort = 1'b0;
    step();

    // Reset in the middle of a run.
    set_cfg(64'hC3B2A1, 8'd3, 8'd0, 8'd0, 8'd0, 8'h00);
    drive_cfg();
    I_start = 1'b1;
    step();
    I_start = 1'b0;
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_all("rst.mid", 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check_all("rst.idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Inter-repetition gap content: filler or idle depending on build.
    set_cfg(64'h55, 8'd1, 8'd0, 8'd1, 8'd2, 8'hEE);
    drive_cfg();
    I_start = 1'b1;
    step();
    I_start = 1'b0;
    check_all("fill.t1", 1'b1, 8'h55, 1'b1, 1'b0);
    step();
    check_all("fill.t2", FV, FD, 1'b1, 1'b0);
    step();
    check_all("fill.t3", FV, FD, 1'b1, 1'b0);
    step();
    check_all("fill.t4", 1'b1, 8'h55, 1'b1, 1'b0);
    step();
    check_all("fill.t5", 1'b0, 8'h00, 1'b0, 1'b1);
    step();

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
